// File: rtl/osd_field_scheduler.sv
// Round-robin scheduler for the OSD character RAM write port: formats a 5-bit signed value as sign/tens/units ASCII.
// Optional build macro OSD_SCHED_DEDUP_EN skips RAM writes when a requester resends its last written value.
module osd_field_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*5-1:0]          req_value,
  output logic                          wr_en,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [7:0]                    wr_data,
  output logic                          show_pulse,
  output logic                          busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Handshake: a requester holds req_valid until it sees req_ready in the same
  // cycle; req_ready is one-hot, only in IDLE, and never depends on anything
  // but req_valid and last_grant. Acceptance is req_valid[i] & req_ready[i].
  typedef enum logic [2:0] {IDLE, FORMAT, WR_SIGN, WR_TENS, WR_UNITS} state_t;

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       last_grant, winner;
  logic                   found, accept, dup;
  int                     cand;
  logic [ADDR_WIDTH-1:0]  base_addr;
  logic [4:0]             value, mag, units_bin;
  logic                   neg, tens_ge;
  logic [7:0]             sign_c, tens_c, units_c;

  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    cand   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign accept = (state == IDLE) && found;
  assign busy   = (state != IDLE);

  // Two's-complement magnitude in 5 bits, so -16 maps to 16.
  assign neg       = value[4];
  assign mag       = neg ? (~value + 5'd1) : value;
  assign tens_ge   = (mag >= 5'd10);
  assign units_bin = tens_ge ? (mag - 5'd10) : mag;
  assign sign_c    = neg ? 8'h2D : 8'h2B;
  assign tens_c    = tens_ge ? 8'h31 : 8'h20;
  assign units_c   = 8'h30 + {3'b000, units_bin};

`ifdef OSD_SCHED_DEDUP_EN
  logic [4:0]         last_val [NUM_REQ];
  logic [NUM_REQ-1:0] last_ok;

  assign dup = last_ok[last_grant] && (last_val[last_grant] == value);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_ok <= '0;
      for (int i = 0; i < NUM_REQ; i++) last_val[i] <= '0;
    end else if (state == WR_TENS) begin
      last_ok[last_grant]  <= 1'b1;
      last_val[last_grant] <= value;
    end
  end
`else
  assign dup = 1'b0;
`endif

  // Each state schedules the write that appears on the port in the following
  // cycle; the units write is on the port during the first IDLE cycle, so
  // WR_UNITS is only a recovery encoding that returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (accept) state_nxt = FORMAT;
      FORMAT:   state_nxt = dup ? IDLE : WR_SIGN;
      WR_SIGN:  state_nxt = WR_TENS;
      WR_TENS:  state_nxt = IDLE;
      WR_UNITS: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      base_addr  <= '0;
      value      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      show_pulse <= 1'b0;
    end else begin
      state      <= state_nxt;
      show_pulse <= accept;
      wr_en      <= 1'b0;
      if (accept) begin
        base_addr  <= req_addr[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
        value      <= req_value[int'(winner)*5 +: 5];
        last_grant <= winner;
      end
      case (state)
        FORMAT: begin
          if (!dup) begin
            wr_en   <= 1'b1;
            wr_addr <= base_addr;
            wr_data <= sign_c;
          end
        end
        WR_SIGN: begin
          wr_en   <= 1'b1;
          wr_addr <= base_addr + ADDR_WIDTH'(1);
          wr_data <= tens_c;
        end
        WR_TENS: begin
          wr_en   <= 1'b1;
          wr_addr <= base_addr + ADDR_WIDTH'(2);
          wr_data <= units_c;
        end
        default: ;
      endcase
    end
  end

endmodule
